// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader: FSM states and image framing.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        StLenLo,
        StLenHi,
        StLoad,
        StRun,
        StError
    } state_e;

    localparam int unsigned NumLanes    = 4;
    localparam int unsigned LaneIdxW    = $clog2(NumLanes);
    localparam int unsigned HeaderBytes = 2;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into little-endian 32-bit words; word_valid pulses the cycle
// after the final lane is captured.
module word_assembler
    import boot_loader_pkg::*;
(
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [7:0]              byte_data,
    input  logic                    byte_valid,
    output logic [8*NumLanes-1:0]   word,
    output logic                    word_valid
);

    logic [LaneIdxW-1:0] lane_q;

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            lane_q     <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && (lane_q == LaneIdxW'(NumLanes - 1));
            if (byte_valid) begin
                word[{lane_q, 3'b000} +: 8] <= byte_data;
                // Lane index wraps naturally from the last lane back to 0.
                lane_q <= lane_q + LaneIdxW'(1);
            end
        end
    end

endmodule

// File: rtl/boot_loader_controller.sv
// Loads a length-prefixed image from the UART into instruction RAM, then releases
// the core from reset and hands it the RAM read port.
module boot_loader_controller
    import boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [31:0]           cpu_memory_address,
    input  logic                  cpu_memory_read_strobe,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic                  mem_write_enable,
    output logic                  mem_read_strobe,
    output logic                  cpu_reset,
    output logic                  load_busy,
    output logic                  load_error
);

    localparam int unsigned       IdleW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IdleW-1:0]  IdleLimit = IdleW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]       MaxWords  = 17'd1 << ADDR_WIDTH;

    state_e                state;
    logic [15:0]           len;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [IdleW-1:0]      idle_cnt;

    logic [31:0]           asm_word;
    logic                  asm_valid;
    logic                  asm_clear;
    logic                  asm_byte_valid;
    logic                  timing;
    logic                  timed_out;
    logic                  last_word;
    logic                  run;
    logic [15:0]           n_words;
    logic [16:0]           next_cnt;
    logic                  unused_cpu_addr;

    word_assembler u_word_assembler (
        .CLK        (CLK),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_data  (rx_data),
        .byte_valid (asm_byte_valid),
        .word       (asm_word),
        .word_valid (asm_valid)
    );

    always_comb begin
        run            = (state == StRun);
        timing         = (state == StLenHi) || (state == StLoad);
        asm_clear      = (state == StLenHi) && rx_valid;
        asm_byte_valid = (state == StLoad) && rx_valid;
        n_words        = {rx_data, len[7:0]};
        // A byte arriving on the limit cycle takes priority over the timeout.
        timed_out      = timing && (idle_cnt == IdleLimit) && !rx_valid;
        next_cnt       = 17'(word_cnt) + 17'd1;
        last_word      = (next_cnt == {1'b0, len});
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= StLenLo;
            len       <= '0;
            word_cnt  <= '0;
            idle_cnt  <= '0;
            cpu_reset <= 1'b1;
        end else begin
            if (rx_valid || !timing) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IdleW'(1);
            end

            case (state)
                StLenLo: begin
                    if (rx_valid) begin
                        len[7:0] <= rx_data;
                        state    <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (rx_valid) begin
                        len      <= n_words;
                        word_cnt <= '0;
                        if (n_words == 16'd0) begin
                            state     <= StRun;
                            cpu_reset <= 1'b0;
                        end else if ({1'b0, n_words} > MaxWords) begin
                            state <= StError;
                        end else begin
                            state <= StLoad;
                        end
                    end else if (timed_out) begin
                        state <= StError;
                    end
                end
                StLoad: begin
                    if (asm_valid) begin
                        word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
                        if (last_word) begin
                            state     <= StRun;
                            cpu_reset <= 1'b0;
                        end
                    end else if (timed_out) begin
                        state <= StError;
                    end
                end
                StRun: begin
                    cpu_reset <= 1'b0;
                end
                StError: begin
                    cpu_reset <= 1'b1;
                end
                default: begin
                    state     <= StError;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

    // Core fetches see the RAM directly so its one-cycle read latency is preserved.
    always_comb begin
        mem_address      = run ? cpu_memory_address[ADDR_WIDTH-1:0] : word_cnt[ADDR_WIDTH-1:0];
        mem_read_strobe  = run && cpu_memory_read_strobe;
        mem_write_enable = (state == StLoad) && asm_valid && !reset;
        mem_write_data   = asm_word;
        load_busy        = timing;
        load_error       = (state == StError);
    end

    assign unused_cpu_addr = ^cpu_memory_address[31:ADDR_WIDTH];

endmodule

// File: tb/tb_boot_loader_controller.sv
// Scoreboard bench: expected RAM writes are queued as bytes are driven and checked on each write.
module tb_boot_loader_controller;

    localparam int unsigned AW = 8;
    localparam int unsigned TO = 16;

    logic          CLK = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [31:0]   cpu_memory_address;
    logic          cpu_memory_read_strobe;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_write_enable;
    logic          mem_read_strobe;
    logic          cpu_reset;
    logic          load_busy;
    logic          load_error;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    logic mon_has;
    logic prev_we = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int n_writes = 0;
    int w0;

    boot_loader_controller #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK                    (CLK),
        .reset                  (reset),
        .rx_data                (rx_data),
        .rx_valid               (rx_valid),
        .cpu_memory_address     (cpu_memory_address),
        .cpu_memory_read_strobe (cpu_memory_read_strobe),
        .mem_address            (mem_address),
        .mem_write_data         (mem_write_data),
        .mem_write_enable       (mem_write_enable),
        .mem_read_strobe        (mem_read_strobe),
        .cpu_reset              (cpu_reset),
        .load_busy              (load_busy),
        .load_error             (load_error)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (mem_write_enable === 1'b1) begin
            n_writes++;
            check_eq("we_single", {31'd0, prev_we}, 32'd0);
            check_eq("rs_in_load", {31'd0, mem_read_strobe}, 32'd0);
            mon_has = (sb.size() > 0);
            check_eq("wr_expected", {31'd0, mon_has}, 32'd1);
            if (mon_has) begin
                mon_e = sb.pop_front();
                check_eq("wr_addr", {24'd0, mem_address}, {24'd0, mon_e.addr});
                check_eq("wr_data", mem_write_data, mon_e.data);
            end
        end
        prev_we <= mem_write_enable;
    end

    // All stimulus tasks start and end just after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic resync();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
        sb.push_back(wr_t'{addr: a, data: w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                  = 1'b1;
        rx_data                = 8'h00;
        rx_valid               = 1'b0;
        cpu_memory_address     = 32'h0000_01AB;
        cpu_memory_read_strobe = 1'b1;
        @(posedge CLK);
        #1;

        // Two-word image.
        do_reset();
        @(negedge CLK);
        check_eq("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("rst_we", {31'd0, mem_write_enable}, 32'd0);
        check_eq("rst_rs", {31'd0, mem_read_strobe}, 32'd0);
        check_eq("rst_busy", {31'd0, load_busy}, 32'd0);
        check_eq("rst_error", {31'd0, load_error}, 32'd0);
        check_eq("rst_addr", {24'd0, mem_address}, 32'd0);
        check_eq("rst_data", mem_write_data, 32'd0);
        resync();
        send_byte(8'h02);
        send_byte(8'h00);
        @(negedge CLK);
        check_eq("t1_busy", {31'd0, load_busy}, 32'd1);
        resync();
        send_word(AW'(0), 32'h0050_0013);
        send_word(AW'(1), 32'h0010_0093);
        @(negedge CLK);
        check_eq("t1_last_we", {31'd0, mem_write_enable}, 32'd1);
        check_eq("t1_cpu_rst_hold", {31'd0, cpu_reset}, 32'd1);
        @(negedge CLK);
        check_eq("t1_cpu_rst_fall", {31'd0, cpu_reset}, 32'd0);
        check_eq("t1_busy_done", {31'd0, load_busy}, 32'd0);
        check_eq("t1_we_off", {31'd0, mem_write_enable}, 32'd0);
        resync();
        check_eq("t1_drain", sb.size(), 32'd0);

        // Run mode: core owns the RAM port, UART bytes ignored.
        cpu_memory_address     = 32'h0000_0105;
        cpu_memory_read_strobe = 1'b1;
        @(negedge CLK);
        check_eq("run_addr", {24'd0, mem_address}, 32'h05);
        check_eq("run_rs", {31'd0, mem_read_strobe}, 32'd1);
        resync();
        cpu_memory_read_strobe = 1'b0;
        @(negedge CLK);
        check_eq("run_rs_low", {31'd0, mem_read_strobe}, 32'd0);
        resync();
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
        @(negedge CLK);
        check_eq("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        resync();
        cpu_memory_address     = 32'h0000_01AB;
        cpu_memory_read_strobe = 1'b1;

        // Empty image.
        do_reset();
        w0 = n_writes;
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge CLK);
        check_eq("t2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_eq("t2_busy", {31'd0, load_busy}, 32'd0);
        check_eq("t2_mux_addr", {24'd0, mem_address}, 32'hAB);
        resync();
        check_eq("t2_no_writes", n_writes - w0, 32'd0);

        // Timeout, including a byte arriving exactly on the limit cycle.
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(AW'(0), 32'hCAFE_F00D);
        idle(TO - 1);
        send_byte(8'h77);
        idle(TO - 1);
        @(negedge CLK);
        check_eq("t3_not_early", {31'd0, load_error}, 32'd0);
        @(negedge CLK);
        check_eq("t3_error", {31'd0, load_error}, 32'd1);
        check_eq("t3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check_eq("t3_busy", {31'd0, load_busy}, 32'd0);
        resync();
        for (int i = 0; i < 6; i++) send_byte(8'hA0 + 8'(i));
        @(negedge CLK);
        check_eq("t3_sticky", {31'd0, load_error}, 32'd1);
        check_eq("t3_cpu_sticky", {31'd0, cpu_reset}, 32'd1);
        resync();
        check_eq("t3_drain", sb.size(), 32'd0);

        // Oversized header.
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge CLK);
        check_eq("t4_oversize_err", {31'd0, load_error}, 32'd1);
        check_eq("t4_oversize_busy", {31'd0, load_busy}, 32'd0);
        resync();

        // Full-depth image.
        do_reset();
        w0 = n_writes;
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 256; i++) send_word(AW'(i), $urandom());
        @(negedge CLK);
        check_eq("t4_last_we", {31'd0, mem_write_enable}, 32'd1);
        check_eq("t4_last_addr", {24'd0, mem_address}, 32'hFF);
        @(negedge CLK);
        check_eq("t4_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check_eq("t4_no_error", {31'd0, load_error}, 32'd0);
        resync();
        check_eq("t4_write_count", n_writes - w0, 32'd256);
        check_eq("t4_drain", sb.size(), 32'd0);

        // Reset mid-word, then reload.
        do_reset();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        do_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(AW'(0), 32'hDEAD_BEEF);
        @(negedge CLK);
        check_eq("t6_we", {31'd0, mem_write_enable}, 32'd1);
        check_eq("t6_data", mem_write_data, 32'hDEAD_BEEF);
        @(negedge CLK);
        check_eq("t6_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        resync();
        check_eq("t6_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
